c4_move_ctrl: RTL

- Sequences each Connect Four move from player input to VGA drawing.
- Accepts a column request and checks it for legality. On a legal move, updates the per-column fill registers and requests the VGA drawer to paint the piece, then hands the turn to the other player.
- Sits between the input debounce/select logic and the VGA piece drawer. Owns the board occupancy state and the turn state.

---
 rtl/c4_pkg.sv | 37 +++
 rtl/c4_move_ctrl_if.sv | 30 +++
 rtl/find_vga_row.sv | 25 ++
 rtl/c4_move_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/c4_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// c4_pkg : board geometry, controller states and column helper for c4_move_ctrl
// rev 1.0
// ----------------------------------------------------------------------------
package c4_pkg;

  localparam int NUM_COLS = 7;
  localparam int NUM_ROWS = 6;
  localparam int COL_W    = 3;
  localparam int BOARD_W  = NUM_ROWS * NUM_COLS;
  localparam int CELLS    = NUM_COLS * NUM_ROWS;
  localparam int CNT_W    = 6;

  localparam logic PLAYER1 = 1'b0;
  localparam logic PLAYER2 = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHECK     = 2'd1,
    DRAW_WAIT = 2'd2,
    FULL      = 2'd3
  } state_t;

  // Out-of-range column indices return an empty column instead of indexing past the board.
  function automatic logic [NUM_ROWS-1:0] col_slice(input logic [BOARD_W-1:0] onoff,
                                                    input logic [COL_W-1:0]   col);
    logic [NUM_ROWS-1:0] s;
    s = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (col == COL_W'(i)) s = onoff[NUM_ROWS*i +: NUM_ROWS];
    end
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/c4_move_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// c4_move_ctrl_if : move request and VGA draw handshake bundle
// rev 1.0
// ----------------------------------------------------------------------------
interface c4_move_ctrl_if;
  import c4_pkg::*;

  logic             move_valid;
  logic [COL_W-1:0] move_col;
  logic             move_ready;
  logic             illegal_move;
  logic             draw_req;
  logic [COL_W-1:0] draw_col;
  logic [2:0]       draw_row;
  logic             draw_player;
  logic             draw_done;

  modport master (
    input  move_valid, move_col, draw_done,
    output move_ready, illegal_move, draw_req, draw_col, draw_row, draw_player
  );

  modport slave (
    output move_valid, move_col, draw_done,
    input  move_ready, illegal_move, draw_req, draw_col, draw_row, draw_player
  );

endinterface
`default_nettype wire

// File: rtl/find_vga_row.sv
`default_nettype none
// ----------------------------------------------------------------------------
// find_vga_row : maps a column thermometer fill to the row of its top piece
// rev 1.0
// ----------------------------------------------------------------------------
module find_vga_row (
  input  logic [5:0] onoff,
  output logic [2:0] row
);

  always_comb begin
    row = 3'd0;
    case (onoff)
      6'b000001: row = 3'd0;
      6'b000011: row = 3'd1;
      6'b000111: row = 3'd2;
      6'b001111: row = 3'd3;
      6'b011111: row = 3'd4;
      6'b111111: row = 3'd5;
      default:   row = 3'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/c4_move_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// c4_move_ctrl : legality check, board update and draw sequencing per move
// rev 1.0
// ----------------------------------------------------------------------------
module c4_move_ctrl
  import c4_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 new_game,
  c4_move_ctrl_if.master       bus,
  output logic                 cur_player,
  output logic [BOARD_W-1:0]   col_onoff,
  output logic                 board_full
);

  state_t               state_q, state_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [BOARD_W-1:0]   onoff_q, onoff_d;
  logic                 player_q, player_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 illegal_q, illegal_d;
  logic                 draw_req_q, draw_req_d;
  logic [COL_W-1:0]     draw_col_q, draw_col_d;
  logic [2:0]           draw_row_q, draw_row_d;
  logic                 draw_player_q, draw_player_d;

  logic [NUM_ROWS-1:0]  sel_col;
  logic [NUM_ROWS-1:0]  new_col;
  logic [2:0]           new_row;
  logic                 legal;

  assign sel_col = col_slice(onoff_q, col_q);
  assign new_col = {sel_col[NUM_ROWS-2:0], 1'b1};
  assign legal   = (int'(col_q) < NUM_COLS) && !sel_col[NUM_ROWS-1];

  find_vga_row u_find_vga_row (
    .onoff (new_col),
    .row   (new_row)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      col_q         <= '0;
      onoff_q       <= '0;
      player_q      <= PLAYER1;
      count_q       <= '0;
      illegal_q     <= 1'b0;
      draw_req_q    <= 1'b0;
      draw_col_q    <= '0;
      draw_row_q    <= '0;
      draw_player_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      onoff_q       <= onoff_d;
      player_q      <= player_d;
      count_q       <= count_d;
      illegal_q     <= illegal_d;
      draw_req_q    <= draw_req_d;
      draw_col_q    <= draw_col_d;
      draw_row_q    <= draw_row_d;
      draw_player_q <= draw_player_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    onoff_d       = onoff_q;
    player_d      = player_q;
    count_d       = count_q;
    illegal_d     = 1'b0;
    draw_req_d    = draw_req_q;
    draw_col_d    = draw_col_q;
    draw_row_d    = draw_row_q;
    draw_player_d = draw_player_q;

    if (new_game) begin
      state_d       = IDLE;
      col_d         = '0;
      onoff_d       = '0;
      player_d      = PLAYER1;
      count_d       = '0;
      draw_req_d    = 1'b0;
      draw_col_d    = '0;
      draw_row_d    = '0;
      draw_player_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.move_valid) begin
            col_d   = bus.move_col;
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (legal) begin
            for (int i = 0; i < NUM_COLS; i++) begin
              if (col_q == COL_W'(i)) onoff_d[NUM_ROWS*i +: NUM_ROWS] = new_col;
            end
            draw_req_d    = 1'b1;
            draw_col_d    = col_q;
            draw_row_d    = new_row;
            draw_player_d = player_q;
            state_d       = DRAW_WAIT;
          end else begin
            illegal_d = 1'b1;
            state_d   = IDLE;
          end
        end
        DRAW_WAIT: begin
          if (bus.draw_done) begin
            draw_req_d = 1'b0;
            player_d   = ~player_q;
            count_d    = count_q + 1'b1;
            state_d    = (count_q == CNT_W'(CELLS - 1)) ? FULL : IDLE;
          end
        end
        FULL: begin
          state_d = FULL;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.move_ready   = (state_q == IDLE);
  assign bus.illegal_move = illegal_q;
  assign bus.draw_req     = draw_req_q;
  assign bus.draw_col     = draw_col_q;
  assign bus.draw_row     = draw_row_q;
  assign bus.draw_player  = draw_player_q;
  assign cur_player       = player_q;
  assign col_onoff        = onoff_q;
  assign board_full       = (state_q == FULL);

endmodule
`default_nettype wire
